mano_io_terminal: RTL and testbench

Device-side end of the basic computer's programmed-I/O interface. It supplies the INPR byte and FGI flag to the core, accepts OUTR bytes and owns FGO, and keeps the interrupt-enable flip-flop and interrupt request. Toward the outside world it exposes byte-wide valid/ready streams: one from a keyboard-like source and one to a printer-like sink. It sits beside the core, in place of the core's unused inpr/outr registers.

---
 rtl/mano_io_terminal.sv | 153 +++++++++++++++
 tb/tb_mano_io_terminal.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mano_io_terminal.sv
// mano_io_terminal: device-side end of the basic computer's programmed I/O.
// It provides INPR/FGI from a small receive FIFO fed by a valid/ready
// source, and accepts OUTR into a three-state transmit FSM that owns FGO
// and drives a valid/ready sink. It also holds the interrupt enable and
// raises the interrupt request.
//
// TX FSM states
//   state  | meaning
//   S_IDLE | fgo=1, waiting for out_wr from the core
//   S_SEND | byte offered to the sink, tx_data held stable
//   S_GAP  | device busy for TX_DELAY cycles before fgo returns
module mano_io_terminal #(
    parameter int RX_DEPTH = 4,
    parameter int TX_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] inpr,
    output logic       fgi,
    input  logic       inp_ack,
    input  logic [7:0] outr,
    input  logic       out_wr,
    output logic       fgo,
    input  logic       ien_set,
    input  logic       ien_clr,
    output logic       ien,
    output logic       irq,
    output logic       ovr,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = (TX_DELAY > 2) ? $clog2(TX_DELAY) : 1;
    localparam logic [CW-1:0] GAP_LOAD = (TX_DELAY > 0) ? CW'(TX_DELAY - 1) : '0;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(RX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } tx_state_e;

    // ---------------- receive FIFO ----------------
    logic [7:0]    mem_q [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          empty, full, push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    // A push is blocked while full even if a pop happens in the same cycle.
    assign push     = rx_valid & ~full;
    assign pop      = inp_ack & ~empty;
    assign fgi      = ~empty;
    assign rx_ready = ~full;
    assign inpr     = empty ? 8'h00 : mem_q[rd_ptr_q];

    // FIFO pointers and occupancy; count is one bit wider than the pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    // ---------------- transmit FSM ----------------
    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          ovr_q, ovr_d;
    logic          ien_q, ien_d;

    // State and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            ovr_q     <= 1'b0;
            ien_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            ovr_q     <= ovr_d;
            ien_q     <= ien_d;
        end
    end

    // Next-state: transmit handshake, busy gap, overrun and interrupt enable
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        ovr_d     = ovr_q | (out_wr & (state_q != S_IDLE));
        ien_d     = ien_q;
        if (ien_clr)      ien_d = 1'b0;
        else if (ien_set) ien_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (out_wr) begin
                    state_d   = S_SEND;
                    tx_data_d = outr;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (TX_DELAY == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        fgo      = (state_q == S_IDLE);
        tx_valid = (state_q == S_SEND);
        tx_data  = tx_data_q;
        ovr      = ovr_q;
        ien      = ien_q;
        irq      = ien_q & (fgi | (state_q == S_IDLE));
    end

endmodule

// File: tb/tb_mano_io_terminal.sv
// Directed bench for mano_io_terminal with RX_DEPTH=4, TX_DELAY=3.
module tb_mano_io_terminal;

    logic       clk;
    logic       rst;
    logic [7:0] inpr;
    logic       fgi;
    logic       inp_ack;
    logic [7:0] outr;
    logic       out_wr;
    logic       fgo;
    logic       ien_set;
    logic       ien_clr;
    logic       ien;
    logic       irq;
    logic       ovr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int n_vec;
    int n_miss;
    logic [7:0] sink_q[$];

    mano_io_terminal #(.RX_DEPTH(4), .TX_DELAY(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .inpr     (inpr),
        .fgi      (fgi),
        .inp_ack  (inp_ack),
        .outr     (outr),
        .out_wr   (out_wr),
        .fgo      (fgo),
        .ien_set  (ien_set),
        .ien_clr  (ien_clr),
        .ien      (ien),
        .irq      (irq),
        .ovr      (ovr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sink model: record every byte handed over on the output stream
    always @(posedge clk) begin
        if (rst && tx_valid && tx_ready) sink_q.push_back(tx_data);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_inpr"},     32'(inpr), 32'h00);
        check_val({tag, "_fgi"},      32'(fgi), 0);
        check_val({tag, "_rx_ready"}, 32'(rx_ready), 1);
        check_val({tag, "_fgo"},      32'(fgo), 1);
        check_val({tag, "_tx_valid"}, 32'(tx_valid), 0);
        check_val({tag, "_tx_data"},  32'(tx_data), 32'h00);
        check_val({tag, "_ien"},      32'(ien), 0);
        check_val({tag, "_irq"},      32'(irq), 0);
        check_val({tag, "_ovr"},      32'(ovr), 0);
    endtask

    task automatic wait_fgo(input string tag);
        for (int k = 0; k < 20 && fgo !== 1'b1; k++) tick();
        check_val({tag, "_wait_fgo"}, 32'(fgo), 1);
    endtask

    initial begin
        logic [7:0] exp_b [4];
        n_vec    = 0;
        n_miss   = 0;
        rst      = 1'b0;
        inp_ack  = 1'b0;
        outr     = 8'h00;
        out_wr   = 1'b0;
        ien_set  = 1'b0;
        ien_clr  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ---- reset mid-stream: 2 bytes queued, byte in SEND, ien and ovr set
        rx_valid = 1'b1; rx_data = 8'hA1; tick();
        rx_data = 8'hA2; tick();
        rx_valid = 1'b0;
        out_wr = 1'b1; outr = 8'h77; ien_set = 1'b1; tick();
        ien_set = 1'b0; outr = 8'h88; tick();
        out_wr = 1'b0;
        check_val("pre_rst_inpr", 32'(inpr), 32'hA1);
        check_val("pre_rst_tx_valid", 32'(tx_valid), 1);
        check_val("pre_rst_tx_data", 32'(tx_data), 32'h77);
        check_val("pre_rst_ovr", 32'(ovr), 1);
        check_val("pre_rst_irq", 32'(irq), 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #1;
        rst = 1'b1;
        tick();
        check_val("post_rst_fgo", 32'(fgo), 1);
        check_val("post_rst_fgi", 32'(fgi), 0);

        // ---- fill / drain with a held-off fifth byte
        rx_valid = 1'b1;
        rx_data = 8'h41; tick();
        check_val("fill1_inpr", 32'(inpr), 32'h41);
        rx_data = 8'h42; tick();
        rx_data = 8'h43; tick();
        check_val("fill3_rx_ready", 32'(rx_ready), 1);
        rx_data = 8'h44; tick();
        check_val("full_rx_ready", 32'(rx_ready), 0);
        rx_data = 8'h45; tick();
        check_val("held_rx_ready", 32'(rx_ready), 0);
        check_val("held_inpr", 32'(inpr), 32'h41);
        inp_ack = 1'b1; tick();
        inp_ack = 1'b0;
        check_val("pop1_inpr", 32'(inpr), 32'h42);
        check_val("pop1_rx_ready", 32'(rx_ready), 1);
        tick();
        rx_valid = 1'b0;
        check_val("refill_rx_ready", 32'(rx_ready), 0);
        exp_b[0] = 8'h43; exp_b[1] = 8'h44; exp_b[2] = 8'h45; exp_b[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            inp_ack = 1'b1; tick();
            inp_ack = 1'b0;
            check_val($sformatf("drain%0d_inpr", i), 32'(inpr), 32'(exp_b[i]));
            check_val($sformatf("drain%0d_fgi", i), 32'(fgi), (i < 3) ? 1 : 0);
        end
        inp_ack = 1'b1; tick();
        inp_ack = 1'b0;
        check_val("empty_ack_fgi", 32'(fgi), 0);
        check_val("empty_ack_ovr", 32'(ovr), 0);

        // ---- simultaneous push/pop across pointer wrap
        rx_valid = 1'b1; rx_data = 8'h60; tick();
        for (int i = 0; i < 10; i++) begin
            rx_data = 8'h61 + 8'(i);
            inp_ack = 1'b1;
            tick();
            check_val($sformatf("sim%0d_inpr", i), 32'(inpr), 32'h61 + i);
            check_val($sformatf("sim%0d_fgi", i), 32'(fgi), 1);
        end
        rx_valid = 1'b0; tick();
        inp_ack = 1'b0;
        check_val("sim_end_fgi", 32'(fgi), 0);
        rx_valid = 1'b1; rx_data = 8'h70; inp_ack = 1'b1; tick();
        rx_valid = 1'b0; inp_ack = 1'b0;
        check_val("empty_pushack_inpr", 32'(inpr), 32'h70);
        inp_ack = 1'b1; tick();
        inp_ack = 1'b0;
        check_val("empty_pushack_pop_fgi", 32'(fgi), 0);

        // ---- TX handshake with stalled sink
        sink_q.delete();
        outr = 8'h5A; out_wr = 1'b1; tick();
        out_wr = 1'b0; outr = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("stall%0d_tx_valid", i), 32'(tx_valid), 1);
            check_val($sformatf("stall%0d_tx_data", i), 32'(tx_data), 32'h5A);
            check_val($sformatf("stall%0d_fgo", i), 32'(fgo), 0);
            if (i < 2) tick();
        end
        tx_ready = 1'b1; tick();
        tx_ready = 1'b0;
        check_val("hs_tx_valid", 32'(tx_valid), 0);
        check_val("gap1_fgo", 32'(fgo), 0);
        tick();
        check_val("gap2_fgo", 32'(fgo), 0);
        tick();
        check_val("gap3_fgo", 32'(fgo), 0);
        tick();
        check_val("gap_done_fgo", 32'(fgo), 1);
        check_val("sink_5a_count", 32'(sink_q.size()), 1);
        if (sink_q.size() > 0) check_val("sink_5a_data", 32'(sink_q[0]), 32'h5A);

        // ---- overrun
        sink_q.delete();
        outr = 8'h11; out_wr = 1'b1; tick();
        outr = 8'h22; tick();
        out_wr = 1'b0;
        check_val("ovr_tx_data", 32'(tx_data), 32'h11);
        check_val("ovr_set", 32'(ovr), 1);
        tx_ready = 1'b1; tick();
        tx_ready = 1'b0;
        wait_fgo("ovr1");
        outr = 8'h33; out_wr = 1'b1; tick();
        out_wr = 1'b0;
        check_val("ovr_33_tx_data", 32'(tx_data), 32'h33);
        tx_ready = 1'b1; tick();
        tx_ready = 1'b0;
        wait_fgo("ovr2");
        check_val("ovr_sink_count", 32'(sink_q.size()), 2);
        if (sink_q.size() > 1) begin
            check_val("ovr_sink0", 32'(sink_q[0]), 32'h11);
            check_val("ovr_sink1", 32'(sink_q[1]), 32'h33);
        end
        check_val("ovr_sticky", 32'(ovr), 1);

        // ---- interrupt enable
        check_val("irq_off", 32'(irq), 0);
        ien_set = 1'b1; tick();
        ien_set = 1'b0;
        check_val("ion_ien", 32'(ien), 1);
        check_val("ion_irq", 32'(irq), 1);
        ien_set = 1'b1; ien_clr = 1'b1; tick();
        ien_set = 1'b0; ien_clr = 1'b0;
        check_val("both_ien", 32'(ien), 0);
        check_val("both_irq", 32'(irq), 0);
        ien_set = 1'b1; outr = 8'h99; out_wr = 1'b1; tick();
        ien_set = 1'b0; out_wr = 1'b0;
        check_val("busy_ien", 32'(ien), 1);
        check_val("busy_fgo", 32'(fgo), 0);
        check_val("busy_irq", 32'(irq), 0);
        rx_valid = 1'b1; rx_data = 8'hB0; tick();
        rx_valid = 1'b0;
        check_val("rx_irq_fgi", 32'(fgi), 1);
        check_val("rx_irq", 32'(irq), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
